// File: rtl/sync_fifo.sv
// sync_fifo -- single-clock FIFO with registered read data and status flags.
//
// Purpose:
//   Stores MEM_WIDTH-bit words in a MEM_DEPTH-deep circular buffer.
//   An accepted read loads r_data from the head word on the same edge,
//   so read data appears one cycle after re is sampled. Every status
//   output is a register, loaded from the occupancy the edge produces.
//
// Parameters:
//   MEM_WIDTH  data word width in bits
//   MEM_DEPTH  storage depth in words (power of two, >= 4)
//   ADDR_WIDTH pointer width, $clog2(MEM_DEPTH)
//   AF_LEVEL   almost_full asserts when count >= AF_LEVEL
//   AE_LEVEL   almost_empty asserts when count <= AE_LEVEL
//
// Ports:
//   clk          single clock, rising edge
//   reset_n      asynchronous active-low reset
//   we / w_data  write request and data (ignored while full)
//   re           read request (ignored while empty)
//   r_data       registered read data, holds between reads
//   r_valid      r_data was loaded on the last edge
//   full, empty, almost_full, almost_empty   registered flags
//   count        occupancy in words, 0..MEM_DEPTH
//
// Optional feature (macro SYNC_FIFO_ERR_EN):
//   err_clr      clears the sticky error flags
//   overflow     set by a write presented while full
//   underflow    set by a read presented while empty
//   A set condition on the same edge as err_clr wins.

module sync_fifo #(
  parameter int MEM_WIDTH  = 8,
  parameter int MEM_DEPTH  = 16,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int AF_LEVEL   = MEM_DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  we,
  input  logic                  re,
  input  logic [MEM_WIDTH-1:0]  w_data,
  output logic [MEM_WIDTH-1:0]  r_data,
  output logic                  r_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count
`ifdef SYNC_FIFO_ERR_EN
  ,
  input  logic                  err_clr,
  output logic                  overflow,
  output logic                  underflow
`else
  // error reporting ports are not present in this build
`endif
);

  localparam logic [ADDR_WIDTH-1:0] PTR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_ZERO = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_AF   = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0]   CNT_AE   = (ADDR_WIDTH+1)'(AE_LEVEL);
  localparam logic [MEM_WIDTH-1:0]  DATA_ZERO = {MEM_WIDTH{1'b0}};

  // Storage is deliberately not reset; stale words are unreachable after
  // reset because the pointers and count restart from zero.
  logic [MEM_WIDTH-1:0]  mem_r [MEM_DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [ADDR_WIDTH-1:0] rd_ptr_r;
  logic [ADDR_WIDTH:0]   count_r;
  logic [MEM_WIDTH-1:0]  r_data_r;
  logic                  r_valid_r;
  logic                  full_r;
  logic                  empty_r;
  logic                  almost_full_r;
  logic                  almost_empty_r;

  logic                  wr_ok_s;
  logic                  rd_ok_s;
  logic [ADDR_WIDTH:0]   count_nxt_s;

  // Request qualification against the registered flags: at full the read
  // still goes through and the write is dropped; at empty the reverse.
  always_comb begin
    wr_ok_s = we & ~full_r;
    rd_ok_s = re & ~empty_r;
  end

  // Occupancy after this edge; simultaneous accepted read and write cancel.
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_ok_s, rd_ok_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Memory write port; gated by reset_n so requests during reset are dropped.
  always_ff @(posedge clk) begin
    if (wr_ok_s && reset_n) begin
      mem_r[wr_ptr_r] <= w_data;
    end
  end

  // Pointers wrap naturally because MEM_DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (rd_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

  // Read data register: loads the head word on an accepted read, else holds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_r  <= DATA_ZERO;
      r_valid_r <= 1'b0;
    end else begin
      if (rd_ok_s) begin
        r_data_r  <= mem_r[rd_ptr_r];
        r_valid_r <= 1'b1;
      end else begin
        r_data_r  <= r_data_r;
        r_valid_r <= 1'b0;
      end
    end
  end

  // Count and flags all load from the same next-count value so they never
  // disagree with one another after an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r        <= CNT_ZERO;
      full_r         <= 1'b0;
      empty_r        <= 1'b1;
      almost_full_r  <= 1'b0;
      almost_empty_r <= 1'b1;
    end else begin
      count_r        <= count_nxt_s;
      full_r         <= (count_nxt_s == CNT_FULL);
      empty_r        <= (count_nxt_s == CNT_ZERO);
      almost_full_r  <= (count_nxt_s >= CNT_AF);
      almost_empty_r <= (count_nxt_s <= CNT_AE);
    end
  end

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_r;
  logic underflow_r;
  logic ovf_set_s;
  logic udf_set_s;

  // A rejected request is one presented while the matching flag blocks it.
  always_comb begin
    ovf_set_s = we & full_r;
    udf_set_s = re & empty_r;
  end

  // Sticky error flags; setting takes priority over err_clr.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end else if (err_clr) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
      if (udf_set_s) begin
        underflow_r <= 1'b1;
      end else if (err_clr) begin
        underflow_r <= 1'b0;
      end else begin
        underflow_r <= underflow_r;
      end
    end
  end

  assign overflow  = overflow_r;
  assign underflow = underflow_r;
`else
  // no error tracking in this build
`endif

  assign r_data       = r_data_r;
  assign r_valid      = r_valid_r;
  assign full         = full_r;
  assign empty        = empty_r;
  assign almost_full  = almost_full_r;
  assign almost_empty = almost_empty_r;
  assign count        = count_r;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo (MEM_WIDTH=8, MEM_DEPTH=16).
// A queue-based reference model tracks contents and expected read data;
// one compare process checks every output on each falling edge, and the
// directed scenarios add literal expectations.
module tb_sync_fifo;
  localparam int W = 8;
  localparam int D = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          we = 1'b0;
  logic          re = 1'b0;
  logic [W-1:0]  w_data = 8'h00;
  logic [W-1:0]  r_data;
  logic          r_valid;
  logic          full, empty, almost_full, almost_empty;
  logic [AW:0]   count;
`ifdef SYNC_FIFO_ERR_EN
  logic          err_clr = 1'b0;
  logic          overflow, underflow;
  bit            exp_ovf, exp_udf;
`endif

  always #5 clk = ~clk;

  sync_fifo #(.MEM_WIDTH(W), .MEM_DEPTH(D)) dut (
    .clk(clk), .reset_n(reset_n), .we(we), .re(re), .w_data(w_data),
    .r_data(r_data), .r_valid(r_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count)
`ifdef SYNC_FIFO_ERR_EN
    , .err_clr(err_clr), .overflow(overflow), .underflow(underflow)
`endif
  );

  int n_checks = 0;
  int n_pass = 0;
  bit check_en = 1'b0;

  logic [W-1:0] q[$];
  logic [W-1:0] exp_rdata = 8'h00;
  bit           exp_rvalid = 1'b0;
  bit           wr_ok_m, rd_ok_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: FIFO as a queue, acceptance decided from occupancy.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      exp_rdata = 8'h00;
      exp_rvalid = 1'b0;
`ifdef SYNC_FIFO_ERR_EN
      exp_ovf = 1'b0;
      exp_udf = 1'b0;
`endif
    end else begin
      wr_ok_m = we && (q.size() < D);
      rd_ok_m = re && (q.size() > 0);
`ifdef SYNC_FIFO_ERR_EN
      if (we && q.size() == D) exp_ovf = 1'b1;
      else if (err_clr) exp_ovf = 1'b0;
      if (re && q.size() == 0) exp_udf = 1'b1;
      else if (err_clr) exp_udf = 1'b0;
`endif
      exp_rvalid = rd_ok_m;
      if (rd_ok_m) exp_rdata = q.pop_front();
      if (wr_ok_m) q.push_back(w_data);
    end
  end

  // Compare process: every output against the model on each falling edge.
  always @(negedge clk) begin
    if (check_en) begin
      chk("count", 32'(count), 32'(q.size()));
      chk("full", 32'(full), 32'(q.size() == D));
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("almost_full", 32'(almost_full), 32'(q.size() >= D - 2));
      chk("almost_empty", 32'(almost_empty), 32'(q.size() <= 2));
      chk("r_valid", 32'(r_valid), 32'(exp_rvalid));
      chk("r_data", 32'(r_data), 32'(exp_rdata));
`ifdef SYNC_FIFO_ERR_EN
      chk("overflow", 32'(overflow), 32'(exp_ovf));
      chk("underflow", 32'(underflow), 32'(exp_udf));
`endif
    end
  end

  // Present one cycle of requests; returns 1 time unit after the edge.
  task automatic step(input bit w, input bit r, input logic [W-1:0] d, input bit clr = 1'b0);
    we = w;
    re = r;
    w_data = d;
`ifdef SYNC_FIFO_ERR_EN
    err_clr = clr;
`endif
    @(posedge clk);
    #1;
    we = 1'b0;
    re = 1'b0;
`ifdef SYNC_FIFO_ERR_EN
    err_clr = 1'b0;
`else
    if (clr) w_data = d;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pw, pr;
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_en = 1'b1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_ae", 32'(almost_empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_af", 32'(almost_full), 32'd0);
    chk("rst_rvalid", 32'(r_valid), 32'd0);
    chk("rst_rdata", 32'(r_data), 32'd0);
    reset_n = 1'b1;

    // Fill with 0x01..0x10
    for (int k = 1; k <= 16; k++) begin
      step(1'b1, 1'b0, 8'(k));
      chk("fill_af", 32'(almost_full), 32'(k >= 14));
    end
    chk("fill_count", 32'(count), 32'd16);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_empty", 32'(empty), 32'd0);

    // Drain in order
    for (int k = 1; k <= 16; k++) begin
      step(1'b0, 1'b1, 8'h00);
      chk("drain_data", 32'(r_data), 32'(k));
      chk("drain_valid", 32'(r_valid), 32'd1);
      chk("drain_ae", 32'(almost_empty), 32'((16 - k) <= 2));
    end
    chk("drain_empty", 32'(empty), 32'd1);

`ifdef SYNC_FIFO_ERR_EN
    step(1'b0, 1'b1, 8'h00);
    chk("udf_set", 32'(underflow), 32'd1);
    step(1'b0, 1'b0, 8'h00);
    chk("udf_hold", 32'(underflow), 32'd1);
`endif

    // Two wrap rounds of 12 writes then 12 reads
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 12; k++) step(1'b1, 1'b0, 8'($urandom));
      for (int k = 0; k < 12; k++) step(1'b0, 1'b1, 8'h00);
    end

    // Simultaneous read/write at count 5
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 8'(8'h40 + k));
    for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 8'(8'h60 + k));
    chk("rw5_count", 32'(count), 32'd5);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 8'h00);
    chk("rw5_last", 32'(r_data), 32'h69);

    // Simultaneous read/write at full: 0xAA dropped
    for (int k = 1; k <= 16; k++) step(1'b1, 1'b0, 8'(8'h20 + k));
`ifdef SYNC_FIFO_ERR_EN
    step(1'b1, 1'b0, 8'hBB);
    chk("ovf_set", 32'(overflow), 32'd1);
    step(1'b0, 1'b0, 8'h00);
    chk("ovf_hold", 32'(overflow), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("clr_udf", 32'(underflow), 32'd0);
`endif
    step(1'b1, 1'b1, 8'hAA);
    chk("full_rw_count", 32'(count), 32'd15);
    chk("full_rw_data", 32'(r_data), 32'h21);
    for (int k = 0; k < 15; k++) step(1'b0, 1'b1, 8'h00);
    chk("full_rw_last", 32'(r_data), 32'h30);

    // Simultaneous read/write at empty: no bypass
    step(1'b1, 1'b1, 8'h55);
    chk("empty_rw_valid", 32'(r_valid), 32'd0);
    chk("empty_rw_count", 32'(count), 32'd1);
    step(1'b0, 1'b1, 8'h00);
    chk("empty_rw_data", 32'(r_data), 32'h55);

    // Reset mid-operation at count 7 with r_valid high
    for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 8'(8'h70 + k));
    step(1'b0, 1'b1, 8'h00);
    chk("pre_rst_count", 32'(count), 32'd7);
    #3 reset_n = 1'b0;
    #1;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    chk("mid_rst_rvalid", 32'(r_valid), 32'd0);
    we = 1'b1;
    re = 1'b1;
    w_data = 8'hEE;
    @(posedge clk);
    #1;
    we = 1'b0;
    re = 1'b0;
    reset_n = 1'b1;
    chk("rst_ignore_count", 32'(count), 32'd0);
    step(1'b0, 1'b1, 8'h00);
    chk("post_rst_rvalid", 32'(r_valid), 32'd0);
    chk("post_rst_count", 32'(count), 32'd0);

    // Randomized traffic with varying read/write bias
    for (int b = 0; b < 12; b++) begin
      pw = $urandom_range(10, 90);
      pr = $urandom_range(10, 90);
      for (int k = 0; k < 250; k++) begin
        step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
             8'($urandom), $urandom_range(0, 19) == 0);
      end
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 The module SHALL have a parameter MEM_WIDTH, default 8, giving the data word width in bits.
REQ-002 The module SHALL have a parameter MEM_DEPTH, default 16, giving the storage depth in words; it is a power of two and at least 4.
REQ-003 The module SHALL have a parameter ADDR_WIDTH, default $clog2(MEM_DEPTH), giving the pointer width.
REQ-004 The module SHALL have a parameter AF_LEVEL, default MEM_DEPTH-2, giving the almost_full threshold in words.
REQ-005 The module SHALL have a parameter AE_LEVEL, default 2, giving the almost_empty threshold in words.
REQ-006 The module SHALL have a port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 The module SHALL have a port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 The module SHALL have a port we, input, 1 bit: write request.
REQ-009 The module SHALL have a port re, input, 1 bit: read request.
REQ-010 The module SHALL have a port w_data, input, MEM_WIDTH bits: write data.
REQ-011 The module SHALL have a port r_data, output, MEM_WIDTH bits: registered read data.
REQ-012 The module SHALL have a port r_valid, output, 1 bit: r_data was updated on the last edge.
REQ-013 The module SHALL have ports full, empty, almost_full and almost_empty, each an output of 1 bit: registered status flags.
REQ-014 The module SHALL have a port count, output, ADDR_WIDTH+1 bits: current occupancy in words, 0..MEM_DEPTH.

Function
REQ-015 A write SHALL be accepted iff we=1 and full=0, storing w_data at the write pointer; the write pointer then increments modulo MEM_DEPTH.
REQ-016 A read SHALL be accepted iff re=1 and empty=0; the read pointer then increments modulo MEM_DEPTH.
REQ-017 An accepted read SHALL load r_data with the head word and set r_valid=1 on the same edge, giving data one cycle after re is sampled.
REQ-018 r_valid SHALL be 0 on every edge without an accepted read, and r_data SHALL hold its value.
REQ-019 count SHALL update as follows: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-020 When full with we=1 and re=1, the read SHALL be accepted, the write rejected, and count SHALL become MEM_DEPTH-1.
REQ-021 When empty with we=1 and re=1, the write SHALL be accepted, the read rejected, r_valid SHALL be 0, and count SHALL become 1; there is no write-to-read bypass.
REQ-022 The flags SHALL be registered and consistent with the count value after each edge: full=(count==MEM_DEPTH), empty=(count==0), almost_full=(count>=AF_LEVEL), almost_empty=(count<=AE_LEVEL).
REQ-023 Rejected requests SHALL change no pointer, count, memory word or r_data.
REQ-024 Data SHALL be returned in strict write order across pointer wrap-around.

Reset
REQ-025 While reset_n=0, regardless of clk, the module SHALL hold: pointers=0, count=0, r_data=0, r_valid=0, full=0, almost_full=0, empty=1, almost_empty=1.
REQ-026 Memory contents SHALL NOT be reset, and words written before reset SHALL never be read after it.
REQ-027 Reset asserted mid-operation SHALL discard all stored words, and requests presented while reset_n=0 SHALL be ignored.
REQ-028 The first edge after reset_n rises SHALL operate normally.

Configuration
REQ-029 With macro SYNC_FIFO_ERR_EN defined, the module SHALL add input err_clr (1 bit) and sticky outputs overflow and underflow (1 bit each, reset to 0).
REQ-030 With SYNC_FIFO_ERR_EN defined, overflow SHALL set on a rejected write and underflow SHALL set on a rejected read.
REQ-031 With SYNC_FIFO_ERR_EN defined, both flags SHALL clear on an edge with err_clr=1; a set condition on the same edge wins over err_clr.
REQ-032 Without SYNC_FIFO_ERR_EN, these three ports SHALL be absent and the module SHALL otherwise behave identically.

Verification (MEM_WIDTH=8, MEM_DEPTH=16, defaults otherwise)
REQ-033 The bench SHALL cover: reset, then write 0x01..0x10 on 16 edges -> count=16, full=1, almost_full=1 from count=14, empty=0.
REQ-034 The bench SHALL cover: from full, read 16 edges -> r_data 0x01..0x10 in order, each one cycle after re, r_valid=1 each cycle; empty=1 after the last read, almost_empty=1 from count=2.
REQ-035 The bench SHALL cover: write 12, read 12, write 12, read 12 -> pointers wrap and data matches in order.
REQ-036 The bench SHALL cover: at count=5, we=re=1 for 10 edges -> count stays 5, output order preserved; at full, we=re=1 -> count=15, 0xAA not stored; at empty, we=re=1 -> r_valid=0, count=1.
REQ-037 The bench SHALL cover: at count=7, drive reset_n=0 between edges -> immediate count=0, empty=1, r_valid=0; the next read of empty gives no r_valid.
REQ-038 With SYNC_FIFO_ERR_EN defined, the bench SHALL cover: write when full -> overflow=1 held; read when empty -> underflow=1; err_clr=1 for one edge -> both 0.
